// File: rtl/datapath_sequencer_if.sv
// Command handshake and completion report between a command issuer and the
// datapath sequencer.
interface datapath_sequencer_if #(
    parameter int DATA_W = 64
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [4:0]        cmd_fs;
    logic              cmd_c0;
    logic [4:0]        cmd_d;
    logic [4:0]        cmd_a;
    logic [4:0]        cmd_b;
    logic [DATA_W-1:0] cmd_k;
    logic              done;
    logic [3:0]        done_status;
    logic              err;

    modport master (
        output cmd_valid, cmd_op, cmd_fs, cmd_c0, cmd_d, cmd_a, cmd_b, cmd_k,
        input  cmd_ready, done, done_status, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_fs, cmd_c0, cmd_d, cmd_a, cmd_b, cmd_k,
        output cmd_ready, done, done_status, err
    );
endinterface

// File: rtl/datapath_sequencer.sv
// Expands one macro-command into 1-3 control-word cycles for the register-file/ALU
// datapath, captures the ALU flags and pulses done on completion.
module datapath_sequencer #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    datapath_sequencer_if.slave cmd,
    input  logic [3:0]        Status,
    output logic              W,
    output logic              EN_ALU,
    output logic              EN_B,
    output logic              K_SEL,
    output logic              C0,
    output logic [4:0]        SA,
    output logic [4:0]        SB,
    output logic [4:0]        DA,
    output logic [4:0]        FS,
    output logic [DATA_W-1:0] K
);
    localparam logic [4:0] FS_XOR = 5'b01100;
    localparam logic [4:0] FS_ADD = 5'b01000;

    localparam logic [2:0] OP_ALU_RR = 3'd0;
    localparam logic [2:0] OP_ALU_RI = 3'd1;
    localparam logic [2:0] OP_MOV    = 3'd2;
    localparam logic [2:0] OP_LDI    = 3'd3;
    localparam logic [2:0] OP_SWAP   = 3'd4;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t            state, state_nxt;
    logic [1:0]        step;
    logic [1:0]        last_step;
    logic              accept;
    logic              finish;

    logic [2:0]        op_p0;
    logic [4:0]        fs_p0;
    logic              c0_p0;
    logic [4:0]        d_p0;
    logic [4:0]        a_p0;
    logic [4:0]        b_p0;
    logic [DATA_W-1:0] k_p0;

    logic              illegal;
    logic              alu_type;

    assign illegal  = op_p0[2] & op_p0[1];
    assign alu_type = (op_p0 == OP_ALU_RR) || (op_p0 == OP_ALU_RI) || (op_p0 == OP_LDI);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        cmd.cmd_ready = (state == IDLE);
        accept        = cmd.cmd_valid && (state == IDLE);

        case (op_p0)
            OP_LDI:  last_step = 2'd1;
            OP_SWAP: last_step = (a_p0 == b_p0) ? 2'd0 : 2'd2;
            default: last_step = 2'd0;
        endcase
        finish = (state == EXEC) && (step == last_step);

        if (accept)      state_nxt = EXEC;
        else if (finish) state_nxt = IDLE;

        W      = 1'b0;
        EN_ALU = 1'b0;
        EN_B   = 1'b0;
        K_SEL  = 1'b0;
        C0     = 1'b0;
        SA     = 5'd0;
        SB     = 5'd0;
        DA     = 5'd0;
        FS     = 5'd0;
        K      = '0;

        // Control word comes only from the registered command, so cmd_* may change in EXEC
        if (state == EXEC) begin
            case (op_p0)
                OP_ALU_RR, OP_ALU_RI: begin
                    SA     = a_p0;
                    SB     = b_p0;
                    DA     = d_p0;
                    FS     = fs_p0;
                    C0     = c0_p0;
                    EN_ALU = 1'b1;
                    W      = 1'b1;
                    if (op_p0 == OP_ALU_RI) begin
                        K_SEL = 1'b1;
                        K     = k_p0;
                    end
                end
                OP_MOV: begin
                    SB   = b_p0;
                    DA   = d_p0;
                    EN_B = 1'b1;
                    W    = 1'b1;
                end
                OP_LDI: begin
                    SA     = d_p0;
                    DA     = d_p0;
                    EN_ALU = 1'b1;
                    W      = 1'b1;
                    if (step == 2'd0) begin
                        SB = d_p0;
                        FS = FS_XOR;
                    end else begin
                        FS    = FS_ADD;
                        K_SEL = 1'b1;
                        K     = k_p0;
                    end
                end
                OP_SWAP: begin
                    if (a_p0 != b_p0) begin
                        FS     = FS_XOR;
                        EN_ALU = 1'b1;
                        W      = 1'b1;
                        if (step == 2'd1) begin
                            SA = b_p0;
                            SB = a_p0;
                            DA = b_p0;
                        end else begin
                            SA = a_p0;
                            SB = b_p0;
                            DA = a_p0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step            <= 2'd0;
            op_p0           <= 3'd0;
            fs_p0           <= 5'd0;
            c0_p0           <= 1'b0;
            d_p0            <= 5'd0;
            a_p0            <= 5'd0;
            b_p0            <= 5'd0;
            k_p0            <= '0;
            cmd.done        <= 1'b0;
            cmd.done_status <= 4'd0;
            cmd.err         <= 1'b0;
        end else begin
            cmd.done <= finish;
            if (accept) begin
                step    <= 2'd0;
                op_p0   <= cmd.cmd_op;
                fs_p0   <= cmd.cmd_fs;
                c0_p0   <= cmd.cmd_c0;
                d_p0    <= cmd.cmd_d;
                a_p0    <= cmd.cmd_a;
                b_p0    <= cmd.cmd_b;
                k_p0    <= cmd.cmd_k;
                cmd.err <= 1'b0;
            end else if (finish) begin
                step    <= 2'd0;
                cmd.err <= illegal;
                if (alu_type) cmd.done_status <= Status;
            end else if (state == EXEC) begin
                step <= step + 2'd1;
            end
        end
    end
endmodule
